// File: rtl/fregisters_dump_reader.sv
// Sequential dump reader for the FP register file: walks indices through the
// spare display-select read port and streams {index, data} beats over valid/ready.
module fregisters_dump_reader #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic              iAbort,
    output logic [ADDR_W-1:0] oRegSelect,
    input  logic [DATA_W-1:0] iRegData,
    output logic              oValid,
    input  logic              iReady,
    output logic [ADDR_W-1:0] oIndex,
    output logic [DATA_W-1:0] oData,
    output logic              oBusy,
    output logic              oDone
);

    // state | meaning
    // IDLE  | waiting for iStart, ptr parked at 0
    // FETCH | ptr drives the read port, data captured at end of cycle
    // SEND  | beat offered, held until accepted
    // DONE  | last beat accepted, done pulse issued on exit
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NREGS - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   index_q;
    logic [DATA_W-1:0]   data_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // iStart takes priority over a coincident iAbort here
                    if (iStart) begin
                        state_q <= FETCH;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (iAbort) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else begin
                        data_q  <= iRegData;
                        index_q <= ptr_q;
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // an abort in the same cycle as iReady discards the beat
                    if (iAbort) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (iReady) begin
                        valid_q <= 1'b0;
                        if (ptr_q == LAST_PTR) begin
                            state_q <= DONE;
                        end else begin
                            ptr_q   <= ptr_q + ADDR_W'(1);
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= ~iAbort;
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oRegSelect = ptr_q;
    assign oValid     = valid_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oIndex     = index_q;
    assign oData      = data_q;

endmodule
